// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the program loader and the processor it feeds.
// Holds the default instruction-memory geometry, the loader FSM state
// encodings and a small helper that identifies states in which a new load
// session may begin.
package prog_loader_pkg;

  // Default instruction-memory geometry shared with the processor.
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  // Loader FSM state encodings, kept as plain constants so older
  // processor code that compares raw state bits keeps working.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  typedef logic [2:0] loader_state_t;

  // A session may only begin from a resting state; LOAD and CHECK ignore
  // start so that a running session can never be torn down half way.
  function automatic logic canStart(input loader_state_t st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_FAIL);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
// Bundles every non-clock signal of the program loader: the host-side
// session/word handshake, the instruction-memory port and the status
// outputs towards the processor.
//   master : host side (drives start, word_in, word_valid, word_last and
//            returns memory read data on mem_q)
//   slave  : the loader itself
// Signals:
//   start       one-cycle request to begin a load session
//   word_in     program word offered by the host
//   word_valid  word_in is valid
//   word_last   offered word is the final program word
//   word_ready  loader accepts a word this cycle
//   mem_addr    instruction-memory address (write or readback)
//   mem_data    instruction-memory write data
//   mem_we      instruction-memory write enable
//   mem_q       memory read data, valid one cycle after mem_addr
//   cpu_hold    processor PC held at 0 while high
//   done        load succeeded
//   error       load failed
//   count       number of words written in the session
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic              word_last;
  logic              word_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   count;

  modport master (
    output start, word_in, word_valid, word_last, mem_q,
    input  word_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error, count
  );

  modport slave (
    input  start, word_in, word_valid, word_last, mem_q,
    output word_ready, mem_addr, mem_data, mem_we, cpu_hold, done, error, count
  );

endinterface

// File: rtl/prog_loader_sum.sv
// loader_sum
// Clearable modulo-2^DATA_W accumulator. The loader uses one copy to sum
// the words it writes and another to sum the words it reads back.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears the sum
//   clear_i  clears the sum at the next edge (start of a session)
//   en_i     adds value_i at the next edge
//   value_i  value to accumulate
//   sum_o    current registered sum
module loader_sum
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] value_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  // Clear wins over accumulate; the addition simply wraps at DATA_W bits.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + value_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Loads a program into instruction memory from a valid/ready word stream,
// then reads the whole image back and compares a checksum of what was
// written against a checksum of what was read. The processor is held at
// PC 0 for the duration and released only on a successful load.
// Ports:
//   CLOCK_50  single clock, all logic on its rising edge
//   reset     synchronous active-high reset
//   bus       prog_loader_if.slave (handshake, memory port, status)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          CLOCK_50,
  input logic          reset,
  prog_loader_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  // endPend: the terminal beat of the session has been accepted and its
  // write is going out this cycle; endFail says the terminal beat was the
  // top address without word_last, i.e. the image does not fit.
  logic              endPend_q, endPend_d;
  logic              endFail_q, endFail_d;
  // Readback pipeline: issue* tracks the address on mem_addr this cycle,
  // data* tracks the matching mem_q one cycle later.
  logic [ADDR_W:0]   readIdx_q, readIdx_d;
  logic              issueVld_q, issueVld_d;
  logic              issueLast_q, issueLast_d;
  logic              dataVld_q, dataVld_d;
  logic              dataLast_q, dataLast_d;

  logic              wordReady;
  logic              accept;
  logic              sumClear;
  logic [DATA_W-1:0] wsum, rsum, rsumNext;

  assign wordReady = (state_q == ST_LOAD) && !endPend_q;
  assign accept    = wordReady && bus.word_valid;

  // Including the final read word combinationally lets the verdict be
  // taken on the very cycle that word arrives.
  assign rsumNext = rsum + bus.mem_q;

  // Next-state logic. Writes are only ever launched from an accepted beat,
  // so mem_we defaults low and readback never disturbs memory contents.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memData_d   = memData_q;
    endPend_d   = endPend_q;
    endFail_d   = endFail_q;
    readIdx_d   = readIdx_q;
    issueVld_d  = 1'b0;
    issueLast_d = 1'b0;
    dataVld_d   = issueVld_q;
    dataLast_d  = issueVld_q && issueLast_q;
    sumClear    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (endPend_q) begin
          if (endFail_q) begin
            state_d = ST_FAIL;
          end else begin
            // count is at least 1 here, so address 0 is always read back.
            state_d     = ST_CHECK;
            memAddr_d   = '0;
            issueVld_d  = 1'b1;
            issueLast_d = (count_q == CNT_ONE);
            readIdx_d   = CNT_ONE;
          end
        end else if (accept) begin
          memWe_d   = 1'b1;
          memAddr_d = count_q[ADDR_W-1:0];
          memData_d = bus.word_in;
          count_d   = count_q + CNT_ONE;
          if (bus.word_last) begin
            endPend_d = 1'b1;
            endFail_d = 1'b0;
          end else if (count_q == CNT_LAST) begin
            // Top address used without a last marker: stop instead of
            // wrapping onto address 0.
            endPend_d = 1'b1;
            endFail_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (issueVld_q && !issueLast_q) begin
          memAddr_d   = readIdx_q[ADDR_W-1:0];
          issueVld_d  = 1'b1;
          issueLast_d = (readIdx_q == count_q - CNT_ONE);
          readIdx_d   = readIdx_q + CNT_ONE;
        end
        if (dataVld_q && dataLast_q) begin
          state_d = (rsumNext == wsum) ? ST_DONE : ST_FAIL;
        end
      end

      default: begin
        if (!canStart(state_q)) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d   = ST_LOAD;
          count_d   = '0;
          memAddr_d = '0;
          memData_d = '0;
          endPend_d = 1'b0;
          endFail_d = 1'b0;
          readIdx_d = '0;
          sumClear  = 1'b1;
        end
      end
    endcase
  end

  // State registers. Reset clears memWe as well, which is what cancels a
  // write belonging to a beat accepted in the same cycle as reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      endPend_q   <= 1'b0;
      endFail_q   <= 1'b0;
      readIdx_q   <= '0;
      issueVld_q  <= 1'b0;
      issueLast_q <= 1'b0;
      dataVld_q   <= 1'b0;
      dataLast_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memData_q   <= memData_d;
      endPend_q   <= endPend_d;
      endFail_q   <= endFail_d;
      readIdx_q   <= readIdx_d;
      issueVld_q  <= issueVld_d;
      issueLast_q <= issueLast_d;
      dataVld_q   <= dataVld_d;
      dataLast_q  <= dataLast_d;
    end
  end

  loader_sum #(.DATA_W(DATA_W)) u_wsum (
    .clk     (CLOCK_50),
    .rst     (reset),
    .clear_i (sumClear),
    .en_i    (accept),
    .value_i (bus.word_in),
    .sum_o   (wsum)
  );

  loader_sum #(.DATA_W(DATA_W)) u_rsum (
    .clk     (CLOCK_50),
    .rst     (reset),
    .clear_i (sumClear),
    .en_i    (dataVld_q),
    .value_i (bus.mem_q),
    .sum_o   (rsum)
  );

  assign bus.word_ready = wordReady;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_data   = memData_q;
  assign bus.count      = count_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = (state_q == ST_FAIL);
  assign bus.cpu_hold   = (state_q == ST_LOAD) || (state_q == ST_CHECK) ||
                          (state_q == ST_FAIL);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Drives load sessions into prog_loader against a behavioural instruction
// memory. Each word offered is turned into an expected memory write pushed
// on a queue; an independent monitor pops and compares every write the
// loader issues. Session outcome, count and checksum verdict come from a
// simple model: sum of words written versus sum of words the memory returns.
module tb_prog_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic CLOCK_50 = 1'b0;
  logic reset;

  always #5 CLOCK_50 = ~CLOCK_50;

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t     expQ[$];
  int      checks = 0;
  int      passes = 0;
  int      cycle = 0;
  int      wrCount = 0;
  int      firstWr = -1;
  int      lastWr = -1;
  bit      corrupt = 1'b0;
  bit      expDone;
  int      expCount;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge CLOCK_50) cycle <= cycle + 1;

  // Behavioural memory: synchronous write, one-cycle read latency, with an
  // optional single-bit corruption of address 2 on readback.
  always @(posedge CLOCK_50) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_addr] ^
                 ((corrupt && bus.mem_addr == AW'(2)) ? DW'(4) : DW'(0));
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Write monitor: every mem_we cycle must match the oldest expected write.
  always @(negedge CLOCK_50) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      wrCount++;
      if (firstWr < 0) firstWr = cycle;
      lastWr = cycle;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, none expected",
                 bus.mem_addr, bus.mem_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("write addr", bus.mem_addr, e.addr);
        checkOutput("write data", bus.mem_data, e.data);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " word_ready"}, bus.word_ready, 0);
    checkOutput({tag, " mem_we"}, bus.mem_we, 0);
    checkOutput({tag, " mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, " mem_data"}, bus.mem_data, 0);
    checkOutput({tag, " cpu_hold"}, bus.cpu_hold, 0);
    checkOutput({tag, " done"}, bus.done, 0);
    checkOutput({tag, " error"}, bus.error, 0);
    checkOutput({tag, " count"}, bus.count, 0);
  endtask

  task automatic pulseStart();
    @(negedge CLOCK_50);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    wrCount = 0;
    firstWr = -1;
    lastWr  = -1;
    checkOutput("LOAD word_ready", bus.word_ready, 1);
    checkOutput("LOAD count", bus.count, 0);
    checkOutput("LOAD cpu_hold", bus.cpu_hold, 1);
    checkOutput("LOAD done/error", {bus.done, bus.error}, 0);
  endtask

  // gapMode: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps.
  task automatic applyStimulus(input int n, input int gapMode,
                               input bit patternData, input bit lastFinal);
    int i = 0;
    int guard = 0;
    wr_t e;
    logic [DW-1:0] w;
    logic [DW-1:0] wSum = '0;
    logic [DW-1:0] rSum = '0;
    while (i < n && guard < 20000) begin
      @(negedge CLOCK_50);
      guard++;
      if ((gapMode == 1 && guard % 2 == 0) ||
          (gapMode == 2 && $urandom_range(0, 99) < 35)) begin
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
      end else begin
        w = patternData ? DW'(32'h1000 + i * 32'h1001) : DW'($urandom);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        bus.word_last  = lastFinal && (i == n - 1);
        checkOutput("word_ready in LOAD", bus.word_ready, 1);
        if (bus.word_ready) begin
          e.addr = AW'(i);
          e.data = w;
          expQ.push_back(e);
          wSum += w;
          rSum += w ^ ((corrupt && i == 2) ? DW'(4) : DW'(0));
          i++;
        end
      end
    end
    checkOutput("beats accepted", i, n);
    @(negedge CLOCK_50);
    bus.word_in    = 16'hDEAD;
    bus.word_valid = 1'b1;
    bus.word_last  = 1'b0;
    checkOutput("word_ready after final beat", bus.word_ready, 0);
    expCount = i;
    expDone  = lastFinal && (wSum == rSum);
  endtask

  task automatic waitOutcome(input int budget);
    int k = 0;
    @(negedge CLOCK_50);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    while (!(bus.done || bus.error) && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    checkOutput("outcome within budget", (k < budget), 1);
    checkOutput("done", bus.done, expDone);
    checkOutput("error", bus.error, !expDone);
    checkOutput("cpu_hold", bus.cpu_hold, !expDone);
    checkOutput("count", bus.count, expCount);
    checkOutput("writes outstanding", expQ.size(), 0);
    checkOutput("write pulses", wrCount, expCount);
    repeat (3) @(negedge CLOCK_50);
    checkOutput("outcome holds", {bus.done, bus.error}, {expDone, !expDone});
    expQ.delete();
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkResetState("por");
    reset = 1'b0;

    // Words offered without a session must be ignored.
    @(negedge CLOCK_50);
    bus.word_valid = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("idle word_ready", bus.word_ready, 0);
    checkOutput("idle cpu_hold", bus.cpu_hold, 0);
    bus.word_valid = 1'b0;

    $display("[TB] four back-to-back words");
    pulseStart();
    applyStimulus(4, 0, 1, 1);
    waitOutcome(30);
    checkOutput("back-to-back span", lastWr - firstWr, 3);

    $display("[TB] same load, address 2 corrupted on readback");
    corrupt = 1'b1;
    pulseStart();
    applyStimulus(4, 0, 1, 1);
    waitOutcome(30);
    corrupt = 1'b0;

    $display("[TB] word_valid every other cycle");
    pulseStart();
    applyStimulus(3, 1, 1, 1);
    waitOutcome(30);

    $display("[TB] start pulsed during CHECK");
    pulseStart();
    applyStimulus(8, 0, 0, 1);
    @(negedge CLOCK_50);
    bus.word_valid = 1'b0;
    bus.start      = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    checkOutput("CHECK ignores start: word_ready", bus.word_ready, 0);
    checkOutput("CHECK ignores start: cpu_hold", bus.cpu_hold, 1);
    waitOutcome(40);

    $display("[TB] random sessions");
    for (int s = 0; s < 6; s++) begin
      corrupt = ($urandom_range(0, 2) == 0);
      pulseStart();
      applyStimulus($urandom_range(1, 24), 2, 0, 1);
      waitOutcome(80);
      corrupt = 1'b0;
    end

    $display("[TB] full memory without last");
    pulseStart();
    applyStimulus(1 << AW, 0, 0, 0);
    waitOutcome(20);

    $display("[TB] reset on an accepted beat");
    pulseStart();
    @(negedge CLOCK_50);
    bus.word_in    = 16'h5A5A;
    bus.word_valid = 1'b1;
    bus.word_last  = 1'b0;
    reset          = 1'b1;
    checkOutput("ready on reset beat", bus.word_ready, 1);
    @(negedge CLOCK_50);
    checkResetState("reset mid-LOAD");
    reset          = 1'b0;
    bus.word_valid = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("after reset word_ready", bus.word_ready, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-003 SHALL have port CLOCK_50  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a load session.
REQ-006 SHALL have port word_in  input  DATA_W  meaning the program word offered by the host.
REQ-007 SHALL have port word_valid  input  1  meaning word_in is valid.
REQ-008 SHALL have port word_last  input  1  meaning the offered word is the final program word.
REQ-009 SHALL have port word_ready  output  1  meaning the loader accepts a word this cycle.
REQ-010 SHALL have port mem_addr  output  ADDR_W  meaning the instruction-memory address for write or readback.
REQ-011 SHALL have port mem_data  output  DATA_W  meaning the instruction-memory write data.
REQ-012 SHALL have port mem_we  output  1  meaning the instruction-memory write enable.
REQ-013 SHALL have port mem_q  input  DATA_W  meaning the memory read data, valid 1 cycle after mem_addr.
REQ-014 SHALL have port cpu_hold  output  1  meaning the processor PC is held at 0 while this is high.
REQ-015 SHALL have port done  output  1  meaning the load succeeded.
REQ-016 SHALL have port error  output  1  meaning the load failed.
REQ-017 SHALL have port count  output  ADDR_W+1  meaning the number of words written in the session.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, CHECK, DONE, FAIL.
REQ-019 SHALL go from IDLE, DONE or FAIL to LOAD on start; in LOAD it clears count and both sums, done=0, error=0, cpu_hold=1.
REQ-020 SHALL ignore start while in LOAD or CHECK.
REQ-021 SHALL drive word_ready=1 only in LOAD; a beat is accepted when word_valid && word_ready.
REQ-022 SHALL, for a beat accepted in cycle N, drive mem_we=1, mem_addr=count, mem_data=word_in in cycle N+1 (registered); count increments by 1 and the write sum adds word_in mod 2^DATA_W.
REQ-023 SHALL sustain one accepted beat per cycle, with no bubbles required.
REQ-024 SHALL, on an accepted beat with word_last=1, drop word_ready next cycle and enter CHECK after that write is issued.
REQ-025 SHALL, on an accepted beat at address 2^ADDR_W-1 with word_last=0, write the word, then enter FAIL; no address wrap-around.
REQ-026 SHALL, in CHECK, drive mem_we=0 and issue readback addresses 0..count-1, one per cycle; mem_q is added to a read sum 1 cycle later.
REQ-027 SHALL, one cycle after the last readback data, enter DONE if read sum equals write sum, else FAIL.
REQ-028 SHALL, in DONE, drive done=1 and cpu_hold=0; in FAIL, error=1 and cpu_hold=1; both hold until the next start.
REQ-029 SHALL never assert mem_we outside the cycle following an accepted beat.

Reset
REQ-030 SHALL, on reset, enter IDLE with word_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, error=0, count=0 and the sums cleared.
REQ-031 SHALL give reset priority over all other inputs; reset mid-LOAD or mid-CHECK aborts the session and suppresses any pending write in the following cycle.

Structure
REQ-032 SHALL place the FSM state encodings and the ADDR_W/DATA_W defaults in a shared package or include used by the processor and loader.
REQ-033 SHALL contain one sub-module, loader_sum, a clearable mod-2^DATA_W accumulator instantiated twice (write sum, read sum).

Verification
REQ-034 SHALL verify: start, then 4 back-to-back beats 0x1000,0x2001,0x3002,0x4003 with last on the 4th -> writes to addresses 0..3 on consecutive cycles, 4 readbacks, DONE, count=4, cpu_hold=0.
REQ-035 SHALL verify: the same load with the memory model corrupting address 2 on readback -> FAIL, error=1, cpu_hold=1.
REQ-036 SHALL verify: word_valid toggled every other cycle for 3 words -> exactly 3 mem_we pulses, at addresses 0,1,2.
REQ-037 SHALL verify: 4096 beats with last never set -> 4096 writes ending at address 0xFFF, then FAIL, and never a write to address 0.
REQ-038 SHALL verify: reset asserted on the cycle a beat is accepted in LOAD -> mem_we=0 the next cycle, IDLE, all outputs at reset values.
REQ-039 SHALL verify: start pulsed during CHECK -> ignored, CHECK completes and DONE is reached; a subsequent start re-enters LOAD with count=0.
